pc_sequencer: RTL

- Program-counter and control-flow stage for the bit-instruction core.
- Sits directly upstream of the 16-entry return-address stack. Generates its call/ret/reset strobes and supplies called_from. Consumes return_to.
- Handles sequential stepping, jumps, calls, returns and scan-cycle wrap.
- Guards the stack against overflow, underflow and unbalanced scans, because the stack itself has no such checks.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/pc_sequencer_stack_guard.sv | 33 +++
 rtl/pc_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and sizing for the bit-instruction core control path.
package cpu_pkg;

  localparam int PC_WIDTH    = 10;
  localparam int STACK_DEPTH = 16;

  typedef enum logic [1:0] {
    FLT_NONE  = 2'd0,
    FLT_OVF   = 2'd1,
    FLT_UNF   = 2'd2,
    FLT_UNBAL = 2'd3
  } fault_code_e;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } state_e;

endpackage

// File: rtl/pc_sequencer_stack_guard.sv
// Shadow depth counter for the return-address stack; tells the sequencer
// whether a push or pop would be legal before it strobes the stack.
module stack_guard #(
  parameter int STACK_DEPTH = cpu_pkg::STACK_DEPTH
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       push,
  input  logic       pop,
  output logic [4:0] depth,
  output logic       push_ok,
  output logic       pop_ok
);

  localparam logic [4:0] FULL = 5'(STACK_DEPTH);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      depth <= 5'd0;
    end else if (clear) begin
      depth <= 5'd0;
    end else if (push) begin
      depth <= depth + 5'd1;
    end else if (pop) begin
      depth <= depth - 5'd1;
    end
  end

  assign push_ok = (depth != FULL);
  assign pop_ok  = (depth != 5'd0);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and control-flow FSM; drives the return-address stack
// strobes and refuses any push/pop or scan wrap that would corrupt it.
module pc_sequencer #(
  parameter int PC_WIDTH    = cpu_pkg::PC_WIDTH,
  parameter int PROG_LAST   = 2**PC_WIDTH - 1,
  parameter int STACK_DEPTH = cpu_pkg::STACK_DEPTH
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                stall,
  input  logic                jmp,
  input  logic                call,
  input  logic                ret,
  input  logic                cond,
  input  logic [PC_WIDTH-1:0] target,
  input  logic [PC_WIDTH-1:0] return_to,
  input  logic                clear_fault,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] called_from,
  output logic                stack_call,
  output logic                stack_ret,
  output logic                stack_reset,
  output logic [4:0]          depth,
  output logic                cycle_done,
  output logic                fault,
  output logic [1:0]          fault_code
);

  import cpu_pkg::*;

  localparam logic [PC_WIDTH-1:0] LAST = PC_WIDTH'(PROG_LAST);

  state_e              state;
  logic                push_ok;
  logic                pop_ok;
  logic                run_act;
  logic                ret_req;
  logic                call_req;
  logic                jmp_req;
  logic                guard_clear;
  logic [PC_WIDTH-1:0] pc_inc;

  // Request priority is resolved here so the strobes and the FSM agree.
  assign ret_req  = ret & cond;
  assign call_req = call & cond & ~ret_req;
  assign jmp_req  = jmp & cond & ~ret_req & ~(call & cond);
  assign run_act  = (state == RUN) & enable & ~stall;
  assign pc_inc   = pc + PC_WIDTH'(1);

  assign stack_ret   = run_act & ret_req & pop_ok;
  assign stack_call  = run_act & call_req & push_ok;
  assign stack_reset = (state == INIT) & ~stall;
  assign guard_clear = stack_reset | ((state == FAULT) & clear_fault & ~stall);

  assign called_from = pc;
  assign fault       = (state == FAULT);

  stack_guard #(
    .STACK_DEPTH (STACK_DEPTH)
  ) u_guard (
    .clock   (clock),
    .reset   (reset),
    .clear   (guard_clear),
    .push    (stack_call),
    .pop     (stack_ret),
    .depth   (depth),
    .push_ok (push_ok),
    .pop_ok  (pop_ok)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= INIT;
      pc         <= '0;
      fault_code <= FLT_NONE;
      cycle_done <= 1'b0;
    end else begin
      cycle_done <= 1'b0;
      if (!stall) begin
        case (state)
          INIT: begin
            state      <= IDLE;
            pc         <= '0;
            fault_code <= FLT_NONE;
          end
          IDLE: begin
            if (enable) state <= RUN;
          end
          RUN: begin
            if (!enable) begin
              state <= IDLE;
            end else if (ret_req) begin
              if (pop_ok) begin
                pc <= return_to;
              end else begin
                state      <= FAULT;
                fault_code <= FLT_UNF;
              end
            end else if (call_req) begin
              if (push_ok) begin
                pc <= target;
              end else begin
                state      <= FAULT;
                fault_code <= FLT_OVF;
              end
            end else if (jmp_req) begin
              pc <= target;
            end else if (pc != LAST) begin
              pc <= pc_inc;
            end else if (pop_ok) begin
              // Scan ended with frames still on the stack.
              state      <= FAULT;
              fault_code <= FLT_UNBAL;
            end else begin
              pc         <= '0;
              cycle_done <= 1'b1;
            end
          end
          FAULT: begin
            if (clear_fault) begin
              state      <= INIT;
              pc         <= '0;
              fault_code <= FLT_NONE;
            end
          end
          default: state <= INIT;
        endcase
      end
    end
  end

endmodule
